// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the decoder/mux slice, plus the default
// slave-address table generator used by the top-level parameter.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } hresp_t;

  typedef enum logic [1:0] {
    D_OK,
    D_ERR1,
    D_ERR2
  } dflt_state_t;

  localparam int MAX_SLAVES     = 16;
  localparam int MAX_FIELD_BITS = 32;

  typedef logic [MAX_SLAVES*MAX_FIELD_BITS-1:0] addr_table_t;

  // Flat table with entry i holding the value i, packed at a stride of
  // field_bits; the caller truncates it to its own table width.
  function automatic addr_table_t identity_addrs(input int count, input int field_bits);
    addr_table_t flat;
    addr_table_t mask;
    flat = '0;
    mask = (addr_table_t'(1) << field_bits) - addr_table_t'(1);
    for (int i = 0; i < count; i++) begin
      flat = flat | ((addr_table_t'(i) & mask) << (i * field_bits));
    end
    return flat;
  endfunction

endpackage

// File: rtl/ahb_decoder_mux_if.sv
// Bus bundle between the master/slave fabric and the decoder-mux:
// address phase in, per-slave responses in, selects and muxed response out.
interface ahb_decoder_mux_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SLAVE_COUNT = 4
) ();

  logic [ADDR_WIDTH-1:0]             i_haddr;
  logic [1:0]                        i_htrans;
  logic [SLAVE_COUNT-1:0]            i_hresp;
  logic [SLAVE_COUNT*DATA_WIDTH-1:0] i_hrdata;
  logic [SLAVE_COUNT-1:0]            i_hready;
  logic [SLAVE_COUNT-1:0]            o_sel;
  logic [DATA_WIDTH-1:0]             o_hrdata;
  logic                              o_hresp;
  logic                              o_hready;
  logic                              o_dec_err;

  // The decoder-mux itself.
  modport slave (
    input  i_haddr, i_htrans, i_hresp, i_hrdata, i_hready,
    output o_sel, o_hrdata, o_hresp, o_hready, o_dec_err
  );

  // The fabric driving it.
  modport master (
    output i_haddr, i_htrans, i_hresp, i_hrdata, i_hready,
    input  o_sel, o_hrdata, o_hresp, o_hready, o_dec_err
  );

endinterface

// File: rtl/ahb_default_slave.sv
// Internal default slave: answers unmapped NONSEQ/SEQ transfers with the
// two-cycle AHB ERROR response, and idle/busy ones with zero-wait OKAY.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       i_hclk,
  input  logic       i_hreset,
  input  logic       i_hready_in,
  input  logic       i_sel_dflt,
  input  logic [1:0] i_htrans,
  output logic       o_hready,
  output hresp_t     o_hresp,
  output logic       o_err_pulse
);

  dflt_state_t state_q;
  dflt_state_t state_d;
  logic        err_request;

  assign err_request = i_hready_in && i_sel_dflt &&
                       (htrans_t'(i_htrans) inside {NONSEQ, SEQ});

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge i_hclk or negedge i_hreset) begin
    if (!i_hreset) state_q <= D_OK;
    else           state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    o_hready    = 1'b1;
    o_hresp     = OKAY;
    o_err_pulse = 1'b0;
    unique case (state_q)
      D_OK: begin
        if (err_request) state_d = D_ERR1;
      end
      D_ERR1: begin
        o_hready    = 1'b0;
        o_hresp     = ERROR;
        o_err_pulse = 1'b1;
        state_d     = D_ERR2;
      end
      D_ERR2: begin
        o_hresp = ERROR;
        state_d = err_request ? D_ERR1 : D_OK;
      end
      default: state_d = D_OK;
    endcase
  end

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite one-master interconnect: address decode to a one-hot select,
// data-phase select register, and response mux with a default ERROR slave.
module ahb_decoder_mux
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH           = 32,
  parameter int DATA_WIDTH           = 32,
  parameter int SLAVE_COUNT          = 4,
  parameter int REGISTER_SELECT_BITS = 12,
  parameter int SLAVE_SELECT_BITS    = ADDR_WIDTH - REGISTER_SELECT_BITS,
  parameter logic [SLAVE_COUNT-1:0][SLAVE_SELECT_BITS-1:0] SLAVE_ADDRS =
    (SLAVE_COUNT*SLAVE_SELECT_BITS)'(identity_addrs(SLAVE_COUNT, SLAVE_SELECT_BITS))
) (
  input  logic           i_hclk,
  input  logic           i_hreset,
  ahb_decoder_mux_if.slave bus
);

  localparam int IDX_W = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;

  logic [SLAVE_SELECT_BITS-1:0] field;
  logic [SLAVE_COUNT-1:0]       sel;
  logic                         hit;
  logic [IDX_W-1:0]             idx;
  logic                         dflt_q;
  logic [IDX_W-1:0]             idx_q;
  logic [DATA_WIDTH-1:0]        hrdata;
  hresp_t                       hresp;
  logic                         hready;
  logic                         dslv_hready;
  hresp_t                       dslv_hresp;
  logic                         dslv_err_pulse;
  logic                         unused_offset_bits;

  assign field              = bus.i_haddr[ADDR_WIDTH-1:REGISTER_SELECT_BITS];
  assign unused_offset_bits = ^bus.i_haddr[REGISTER_SELECT_BITS-1:0];

  // Scan from the top down so the lowest matching entry wins on duplicates.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    idx = '0;
    for (int i = SLAVE_COUNT - 1; i >= 0; i--) begin
      if (SLAVE_ADDRS[i] == field) begin
        sel    = '0;
        sel[i] = 1'b1;
        idx    = IDX_W'(i);
        hit    = 1'b1;
      end
    end
  end

  // Data-phase owner only advances when the current data phase completes.
  always_ff @(posedge i_hclk or negedge i_hreset) begin
    if (!i_hreset) begin
      dflt_q <= 1'b1;
      idx_q  <= '0;
    end else if (hready) begin
      dflt_q <= ~hit;
      idx_q  <= idx;
    end
  end

  always_comb begin
    hrdata = '0;
    hresp  = dslv_hresp;
    hready = dslv_hready;
    if (!dflt_q) begin
      hrdata = bus.i_hrdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
      hresp  = hresp_t'(bus.i_hresp[idx_q]);
      hready = bus.i_hready[idx_q];
    end
  end

  ahb_default_slave u_default_slave (
    .i_hclk      (i_hclk),
    .i_hreset    (i_hreset),
    .i_hready_in (hready),
    .i_sel_dflt  (~hit),
    .i_htrans    (bus.i_htrans),
    .o_hready    (dslv_hready),
    .o_hresp     (dslv_hresp),
    .o_err_pulse (dslv_err_pulse)
  );

  assign bus.o_sel     = sel;
  assign bus.o_hrdata  = hrdata;
  assign bus.o_hresp   = hresp;
  assign bus.o_hready  = hready;
  assign bus.o_dec_err = dslv_err_pulse;

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed bench for ahb_decoder_mux: a per-cycle vector table for decode,
// wait states and ERROR sequencing, plus reset and duplicate-table sequences.
module tb_ahb_decoder_mux;
  import ahb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SC  = 4;
  localparam int RSB = 12;
  localparam int NV  = 20;

  localparam logic [31:0] S0  = 32'hDA7A_0000;
  localparam logic [31:0] S1  = 32'hDA7A_0001;
  localparam logic [31:0] S2  = 32'hCAFE_F00D;
  localparam logic [31:0] S3  = 32'hDA7A_0003;
  localparam logic [31:0] UNM = 32'hFFFF_F000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ahb_decoder_mux_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_COUNT(SC)) bus ();
  ahb_decoder_mux_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_COUNT(SC)) dup_bus ();

  ahb_decoder_mux #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_COUNT(SC), .REGISTER_SELECT_BITS(RSB)
  ) dut (
    .i_hclk   (clk),
    .i_hreset (rst_n),
    .bus      (bus)
  );

  ahb_decoder_mux #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_COUNT(SC), .REGISTER_SELECT_BITS(RSB),
    .SLAVE_ADDRS({20'h5, 20'h2, 20'h5, 20'h0})
  ) dut_dup (
    .i_hclk   (clk),
    .i_hreset (rst_n),
    .bus      (dup_bus)
  );

  typedef struct {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [3:0]  rdy_in;
    logic [3:0]  rsp_in;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        rsp;
    logic        rdy;
    logic        dec;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(logic [31:0] a, htrans_t t, logic [3:0] rdy_in,
                              logic [3:0] rsp_in, logic [3:0] sel, logic [31:0] rd,
                              logic rsp, logic rdy, logic dec);
    vec_t v;
    v.haddr = a;   v.htrans = t;   v.rdy_in = rdy_in; v.rsp_in = rsp_in;
    v.sel   = sel; v.rdata  = rd;  v.rsp    = rsp;    v.rdy    = rdy;
    v.dec   = dec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] rd, input logic rsp,
                           input logic rdy, input logic dec);
    check({tag, "_hrdata"},  bus.o_hrdata,  rd);
    check({tag, "_hresp"},   32'(bus.o_hresp),   32'(rsp));
    check({tag, "_hready"},  32'(bus.o_hready),  32'(rdy));
    check({tag, "_dec_err"}, 32'(bus.o_dec_err), 32'(dec));
  endtask

  initial begin
    // Cycle-by-cycle: inputs for the cycle, outputs expected during it.
    vecs[0]  = mk(32'h0000_2010, NONSEQ, 4'hF,    4'h0,    4'b0100, 32'h0, 1'b0, 1'b1, 1'b0);
    vecs[1]  = mk(32'h0000_0000, IDLE,   4'b1011, 4'h0,    4'b0001, S2,    1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(32'h0000_1004, NONSEQ, 4'hF,    4'h0,    4'b0010, S2,    1'b0, 1'b1, 1'b0);
    vecs[3]  = mk(32'h0000_3000, NONSEQ, 4'b1101, 4'h0,    4'b1000, S1,    1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(32'h0000_3008, NONSEQ, 4'b1101, 4'h0,    4'b1000, S1,    1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(32'h0000_3010, NONSEQ, 4'b1101, 4'h0,    4'b1000, S1,    1'b0, 1'b0, 1'b0);
    vecs[6]  = mk(32'h0000_3000, NONSEQ, 4'hF,    4'h0,    4'b1000, S1,    1'b0, 1'b1, 1'b0);
    vecs[7]  = mk(UNM,           NONSEQ, 4'b0111, 4'b1000, 4'b0000, S3,    1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(UNM,           NONSEQ, 4'hF,    4'b1000, 4'b0000, S3,    1'b1, 1'b1, 1'b0);
    vecs[9]  = mk(32'hFFFF_F004, SEQ,    4'hF,    4'h0,    4'b0000, 32'h0, 1'b1, 1'b0, 1'b1);
    vecs[10] = mk(32'hFFFF_F004, SEQ,    4'hF,    4'h0,    4'b0000, 32'h0, 1'b1, 1'b1, 1'b0);
    vecs[11] = mk(32'hFFFF_F008, IDLE,   4'hF,    4'h0,    4'b0000, 32'h0, 1'b1, 1'b0, 1'b1);
    vecs[12] = mk(32'hFFFF_F008, IDLE,   4'hF,    4'h0,    4'b0000, 32'h0, 1'b1, 1'b1, 1'b0);
    vecs[13] = mk(32'h0000_0040, NONSEQ, 4'hF,    4'h0,    4'b0001, 32'h0, 1'b0, 1'b1, 1'b0);
    vecs[14] = mk(32'h0000_0000, IDLE,   4'hF,    4'h0,    4'b0001, S0,    1'b0, 1'b1, 1'b0);
    vecs[15] = mk(UNM,           NONSEQ, 4'hF,    4'h0,    4'b0000, S0,    1'b0, 1'b1, 1'b0);
    vecs[16] = mk(32'h0000_2000, NONSEQ, 4'hF,    4'h0,    4'b0100, 32'h0, 1'b1, 1'b0, 1'b1);
    vecs[17] = mk(32'h0000_2000, NONSEQ, 4'hF,    4'h0,    4'b0100, 32'h0, 1'b1, 1'b1, 1'b0);
    vecs[18] = mk(UNM,           BUSY,   4'hF,    4'h0,    4'b0000, S2,    1'b0, 1'b1, 1'b0);
    vecs[19] = mk(UNM,           IDLE,   4'hF,    4'h0,    4'b0000, 32'h0, 1'b0, 1'b1, 1'b0);

    bus.i_haddr      = UNM;
    bus.i_htrans     = IDLE;
    bus.i_hready     = 4'hF;
    bus.i_hresp      = 4'h0;
    bus.i_hrdata     = {S3, S2, S1, S0};
    dup_bus.i_haddr  = 32'h0;
    dup_bus.i_htrans = IDLE;
    dup_bus.i_hready = 4'hF;
    dup_bus.i_hresp  = 4'h0;
    dup_bus.i_hrdata = {S3, S2, S1, S0};

    repeat (2) @(negedge clk);
    #1;
    check_rsp("reset", 32'h0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.i_haddr  = vecs[i].haddr;
      bus.i_htrans = vecs[i].htrans;
      bus.i_hready = vecs[i].rdy_in;
      bus.i_hresp  = vecs[i].rsp_in;
      #1;
      check($sformatf("v%0d_sel", i), 32'(bus.o_sel), 32'(vecs[i].sel));
      check_rsp($sformatf("v%0d", i), vecs[i].rdata, vecs[i].rsp, vecs[i].rdy, vecs[i].dec);
    end

    // Reset in the middle of a stalled slave-2 data phase.
    @(negedge clk);
    bus.i_haddr  = 32'h0000_2000;
    bus.i_htrans = NONSEQ;
    @(negedge clk);
    bus.i_haddr  = UNM;
    bus.i_htrans = IDLE;
    bus.i_hready = 4'b1011;
    #1;
    check("rstA_pre_hrdata", bus.o_hrdata, S2);
    #1 rst_n = 1'b0;
    #1;
    check("rstA_hrdata", bus.o_hrdata, 32'h0);
    check("rstA_hready", 32'(bus.o_hready), 32'h1);
    check("rstA_hresp",  32'(bus.o_hresp),  32'h0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.i_hready = 4'hF;

    // Reset in the first ERROR cycle abandons the response.
    @(negedge clk);
    bus.i_haddr  = UNM;
    bus.i_htrans = NONSEQ;
    @(negedge clk);
    bus.i_htrans = IDLE;
    #1;
    check("rstB_pre_dec_err", 32'(bus.o_dec_err), 32'h1);
    check("rstB_pre_hready",  32'(bus.o_hready),  32'h0);
    #1 rst_n = 1'b0;
    #1;
    check_rsp("rstB", 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rstB_post_hresp",  32'(bus.o_hresp),  32'h0);
    check("rstB_post_hready", 32'(bus.o_hready), 32'h1);

    // Duplicate table entries: lowest index wins.
    dup_bus.i_haddr = 32'h0000_5000;
    #1 check("dup_5000_sel", 32'(dup_bus.o_sel), 32'b0010);
    dup_bus.i_haddr = 32'h0000_2abc;
    #1 check("dup_2abc_sel", 32'(dup_bus.o_sel), 32'b0100);
    dup_bus.i_haddr = 32'h0000_1000;
    #1 check("dup_1000_sel", 32'(dup_bus.o_sel), 32'b0000);
    dup_bus.i_haddr = 32'h0000_0ffc;
    #1 check("dup_0ffc_sel", 32'(dup_bus.o_sel), 32'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
